// File: rtl/ez90_pkg.sv
// rtl/ez90_pkg.sv - eZ90 shared types used by the reorder buffer
package ez90_pkg;

    // Renamed uop as handed from rename/dispatch to the ROB
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [5:0]  prd;
        logic [5:0]  prs1;
        logic [5:0]  prs2;
        logic        rd_we;
    } ez90_uop_rn_t;

endpackage

// File: rtl/rob_queue_if.sv
// rtl/rob_queue_if.sv - dispatch, writeback and commit-head signals of the ROB
interface rob_queue_if #(
    parameter int IDX_W = 6
);
    import ez90_pkg::*;

    logic               flush;
    logic               alloc_valid;
    ez90_uop_rn_t       alloc_uop;
    logic               alloc_ready;
    logic [IDX_W-1:0]   alloc_idx;
    logic               wb_valid;
    logic [IDX_W-1:0]   wb_idx;
    logic               wb_has_trap;
    logic [31:0]        wb_trap_cause;
    logic               rob_head_valid;
    logic               rob_head_done;
    ez90_uop_rn_t       rob_head_uop;
    logic [IDX_W-1:0]   rob_head_idx;
    logic               rob_head_has_trap;
    logic [31:0]        rob_head_trap_cause;
    logic               rob_head_pop;
    logic [IDX_W:0]     occupancy;
    logic               empty;
    logic               full;

    // Core side: dispatch, writeback units and commit stage
    modport master (
        output flush, alloc_valid, alloc_uop, wb_valid, wb_idx, wb_has_trap,
               wb_trap_cause, rob_head_pop,
        input  alloc_ready, alloc_idx, rob_head_valid, rob_head_done,
               rob_head_uop, rob_head_idx, rob_head_has_trap,
               rob_head_trap_cause, occupancy, empty, full
    );

    // ROB side
    modport slave (
        input  flush, alloc_valid, alloc_uop, wb_valid, wb_idx, wb_has_trap,
               wb_trap_cause, rob_head_pop,
        output alloc_ready, alloc_idx, rob_head_valid, rob_head_done,
               rob_head_uop, rob_head_idx, rob_head_has_trap,
               rob_head_trap_cause, occupancy, empty, full
    );

endinterface

// File: rtl/rob_queue.sv
// rtl/rob_queue.sv - circular in-order reorder buffer for the eZ90 P7 core
module rob_queue #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    rob_queue_if.slave rq
);
    import ez90_pkg::*;

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] tail_q;
    logic [IDX_W:0]   count_q;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] trap_q;
    logic [31:0]      cause_mem [DEPTH];
    ez90_uop_rn_t     uop_mem   [DEPTH];

    logic is_full;
    logic alloc_fire;
    logic pop_fire;
    logic wb_fire;
    logic head_valid;

    // Handshake qualification; no pop-to-alloc bypass when full
    always_comb begin
        is_full    = (count_q == FULL_COUNT);
        head_valid = valid_q[head_q];
        alloc_fire = rq.alloc_valid && !is_full;
        pop_fire   = rq.rob_head_pop && head_valid && done_q[head_q];
        wb_fire    = rq.wb_valid && valid_q[rq.wb_idx];
    end

    // Pointers, counter and per-entry status; flush beats everything,
    // and the pop clears after the writeback so a same-entry pop wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            trap_q  <= '0;
        end else if (rq.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            trap_q  <= '0;
        end else begin
            if (wb_fire) begin
                done_q[rq.wb_idx] <= 1'b1;
                trap_q[rq.wb_idx] <= rq.wb_has_trap;
            end
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                trap_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + IDX_W'(1);
            end
            if (pop_fire) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                trap_q[head_q]  <= 1'b0;
                head_q          <= head_q + IDX_W'(1);
            end
            case ({alloc_fire, pop_fire})
                2'b10:   count_q <= count_q + (IDX_W+1)'(1);
                2'b01:   count_q <= count_q - (IDX_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage; contents of invalid entries never reach the head outputs
    always_ff @(posedge clk) begin
        if (!rst && !rq.flush) begin
            if (wb_fire) begin
                cause_mem[rq.wb_idx] <= rq.wb_trap_cause;
            end
            if (alloc_fire) begin
                cause_mem[tail_q] <= '0;
                uop_mem[tail_q]   <= rq.alloc_uop;
            end
        end
    end

    assign rq.alloc_ready         = !is_full;
    assign rq.alloc_idx           = tail_q;
    assign rq.rob_head_valid      = head_valid;
    assign rq.rob_head_done       = head_valid && done_q[head_q];
    assign rq.rob_head_uop        = head_valid ? uop_mem[head_q] : '0;
    assign rq.rob_head_idx        = head_q;
    assign rq.rob_head_has_trap   = head_valid && trap_q[head_q];
    assign rq.rob_head_trap_cause = head_valid ? cause_mem[head_q] : 32'h0;
    assign rq.occupancy           = count_q;
    assign rq.empty               = (count_q == '0);
    assign rq.full                = is_full;

endmodule
